// File: rtl/sel_debounce_toggle.sv
// sel_debounce_toggle
//
// Push-button front end for the 2:1 selector. The raw button is normalized to
// active-high and passed through a two-flop synchronizer. A four-state FSM
// with a cycle counter debounces the synchronized level. Accepted presses and
// releases produce one-cycle pulses. Each accepted press toggles the
// registered select output.
//
// Parameters:
//   DEBOUNCE_CYCLES  cycles a new synchronized level must hold (>= 2)
//   CNT_WIDTH        counter width, 2**CNT_WIDTH > DEBOUNCE_CYCLES
//   BTN_ACTIVE_LOW   1: btn_in = 0 means pressed
//   SEL_INIT         value of sel after reset
//
// Ports:
//   clk            single clock for all logic
//   rst            asynchronous active-high reset
//   btn_in         raw, asynchronous, bouncing button
//   sel            registered select, drives selector sel0
//   btn_level      debounced button state, 1 = pressed
//   press_pulse    one-cycle pulse when a press is accepted
//   release_pulse  one-cycle pulse when a release is accepted
module sel_debounce_toggle #(
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int CNT_WIDTH       = 18,
  parameter bit BTN_ACTIVE_LOW  = 1'b1,
  parameter bit SEL_INIT        = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic sel,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic                 btn_active;
  logic                 s1_reg;
  logic                 s2_reg;
  state_t               state_reg, state_next;
  logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
  logic                 sel_reg, sel_next;
  logic                 level_reg, level_next;
  logic                 press_reg, press_next;
  logic                 release_reg, release_next;

  // Normalize polarity so that 1 always means "pressed" downstream.
  assign btn_active = btn_in ^ BTN_ACTIVE_LOW;

  // Two-flop synchronizer; only s2_reg feeds the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_reg <= 1'b0;
      s2_reg <= 1'b0;
    end else begin
      s1_reg <= btn_active;
      s2_reg <= s1_reg;
    end
  end

  // State, counter and all outputs are registered together so that the
  // pulses, level and toggled select appear in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      sel_reg     <= SEL_INIT;
      level_reg   <= 1'b0;
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      sel_reg     <= sel_next;
      level_reg   <= level_next;
      press_reg   <= press_next;
      release_reg <= release_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    sel_next     = sel_reg;
    level_next   = level_reg;
    press_next   = 1'b0;
    release_next = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (s2_reg) begin
          // The entering sample already counts as the first held cycle.
          state_next = PRESS_WAIT;
          cnt_next   = CNT_ONE;
        end
      end

      PRESS_WAIT: begin
        if (!s2_reg) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          // DEBOUNCE_CYCLES consecutive active samples: accept the press.
          state_next = PRESSED;
          cnt_next   = '0;
          press_next = 1'b1;
          level_next = 1'b1;
          sel_next   = ~sel_reg;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      PRESSED: begin
        if (!s2_reg) begin
          state_next = RELEASE_WAIT;
          cnt_next   = CNT_ONE;
        end
      end

      RELEASE_WAIT: begin
        if (s2_reg) begin
          state_next = PRESSED;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          // Releases never touch sel.
          state_next   = IDLE;
          cnt_next     = '0;
          release_next = 1'b1;
          level_next   = 1'b0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign sel           = sel_reg;
  assign btn_level     = level_reg;
  assign press_pulse   = press_reg;
  assign release_pulse = release_reg;

endmodule

// File: tb/tb_sel_debounce_toggle.sv
module tb_sel_debounce_toggle;

  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn_in = 1'b1;
  logic sel, btn_level, press_pulse, release_pulse;

  // Selector stand-in: in0 = 0, in1 = 1, sel drives sel0.
  logic in0 = 1'b0;
  logic in1 = 1'b1;
  logic out1;
  assign out1 = sel ? in1 : in0;

  int checks = 0;
  int errors = 0;

  sel_debounce_toggle #(
    .DEBOUNCE_CYCLES(D),
    .CNT_WIDTH(3),
    .BTN_ACTIVE_LOW(1'b1),
    .SEL_INIT(1'b0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_in(btn_in),
    .sel(sel),
    .btn_level(btn_level),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse)
  );

  always #5 clk = ~clk;

  // Reference model: a 2-deep sample delay, then a run-length rule.
  // A synchronized level that differs from the accepted level for D
  // consecutive samples becomes the new accepted level.
  logic m_p1, m_p2, m_level, m_sel, m_press, m_rel;
  int   m_run;

  task automatic model_reset();
    m_p1 = 0; m_p2 = 0; m_level = 0; m_sel = 0;
    m_press = 0; m_rel = 0; m_run = 0;
  endtask

  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else begin
      m_press = 0;
      m_rel   = 0;
      if (m_p2 != m_level) begin
        m_run++;
        if (m_run == D) begin
          m_level = ~m_level;
          m_run   = 0;
          if (m_level) begin
            m_press = 1;
            m_sel   = ~m_sel;
          end else begin
            m_rel = 1;
          end
        end
      end else begin
        m_run = 0;
      end
      m_p2 = m_p1;
      m_p1 = ~btn_in;
    end
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".sel"}, sel, m_sel);
    check({tag, ".level"}, btn_level, m_level);
    check({tag, ".press"}, press_pulse, m_press);
    check({tag, ".release"}, release_pulse, m_rel);
  endtask

  // Drive btn_in, take one clock edge, then compare 1 time unit later.
  task automatic step(input logic b, input string tag);
    btn_in = b;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  // Assert reset between clock edges and check that it acts immediately.
  task automatic async_reset_on(input string tag);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all(tag);
  endtask

  int npress;
  int nrel;
  logic [3:0] out_seq;

  initial begin
    model_reset();

    // Reset values.
    async_reset_on("reset");
    step(1'b1, "reset_hold");
    step(1'b1, "reset_hold");
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, "idle_released");
      check("idle_sel_const", sel, 1'b0);
    end
    $display("reset/idle: sel=%0b level=%0b", sel, btn_level);

    // Clean press: accepted at edge D+2.
    for (int e = 1; e <= 10; e++) begin
      step(1'b0, "clean_press");
      check("clean_press_timing", press_pulse, logic'(e == D + 2));
    end
    check("clean_press_sel", sel, 1'b1);
    check("clean_press_level", btn_level, 1'b1);
    $display("clean press: sel=%0b level=%0b", sel, btn_level);

    // Clean release: accepted at edge D+2, sel unchanged.
    for (int e = 1; e <= 10; e++) begin
      step(1'b1, "clean_release");
      check("clean_release_timing", release_pulse, logic'(e == D + 2));
    end
    check("clean_release_sel", sel, 1'b1);
    $display("clean release: sel=%0b level=%0b", sel, btn_level);

    // Bounce rejection: low 3, high 1, low 2, high 10.
    npress = 0;
    for (int i = 0; i < 3; i++) begin step(1'b0, "bounce_a"); npress += int'(press_pulse); end
    step(1'b1, "bounce_a"); npress += int'(press_pulse);
    for (int i = 0; i < 2; i++) begin step(1'b0, "bounce_a"); npress += int'(press_pulse); end
    for (int i = 0; i < 10; i++) begin step(1'b1, "bounce_a"); npress += int'(press_pulse); end
    checks++;
    assert (npress == 0) else begin
      errors++;
      $error("FAIL bounce_reject_count observed=%0d expected=0", npress);
    end
    check("bounce_reject_sel", sel, 1'b1);
    $display("bounce reject: presses=%0d sel=%0b", npress, sel);

    // Low 3, high 1, low 6: exactly one press.
    npress = 0;
    for (int i = 0; i < 3; i++) begin step(1'b0, "bounce_b"); npress += int'(press_pulse); end
    step(1'b1, "bounce_b"); npress += int'(press_pulse);
    for (int i = 0; i < 6; i++) begin step(1'b0, "bounce_b"); npress += int'(press_pulse); end
    for (int i = 0; i < 2; i++) begin step(1'b0, "bounce_b"); npress += int'(press_pulse); end
    checks++;
    assert (npress == 1) else begin
      errors++;
      $error("FAIL bounce_accept_count observed=%0d expected=1", npress);
    end
    check("bounce_accept_sel", sel, 1'b0);
    $display("bounce accept: presses=%0d sel=%0b", npress, sel);

    for (int i = 0; i < 10; i++) step(1'b1, "release_before_thr");

    // Threshold: D-1 active samples rejected, D accepted.
    npress = 0;
    for (int i = 0; i < D - 1; i++) begin step(1'b0, "thr_short"); npress += int'(press_pulse); end
    for (int i = 0; i < 10; i++) begin step(1'b1, "thr_short"); npress += int'(press_pulse); end
    checks++;
    assert (npress == 0) else begin
      errors++;
      $error("FAIL thr_short_count observed=%0d expected=0", npress);
    end
    npress = 0;
    for (int i = 0; i < D; i++) begin step(1'b0, "thr_exact"); npress += int'(press_pulse); end
    for (int i = 0; i < 10; i++) begin step(1'b1, "thr_exact"); npress += int'(press_pulse); end
    checks++;
    assert (npress == 1) else begin
      errors++;
      $error("FAIL thr_exact_count observed=%0d expected=1", npress);
    end
    check("thr_exact_sel", sel, 1'b1);
    $display("threshold: sel=%0b", sel);

    // Reset mid-debounce with the button held through reset.
    for (int i = 0; i < 4; i++) step(1'b0, "mid_press");
    async_reset_on("mid_reset");
    check("mid_reset_sel", sel, 1'b0);
    step(1'b0, "mid_reset_hold");
    step(1'b0, "mid_reset_hold");
    rst = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      step(1'b0, "held_through_reset");
      check("held_press_timing", press_pulse, logic'(e == D + 2));
    end
    check("held_press_sel", sel, 1'b1);
    $display("reset mid-operation: sel=%0b", sel);

    // Selector integration: 3 presses from sel = 0.
    btn_in = 1'b1;
    async_reset_on("sel_reset");
    step(1'b1, "sel_reset_hold");
    rst = 1'b0;
    out_seq = '0;
    out_seq[0] = out1;
    npress = 0;
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 10; i++) begin
        step(1'b0, "sel_press");
        if (press_pulse && npress < 3) begin
          npress++;
          out_seq[npress] = out1;
        end
      end
      for (int i = 0; i < 10; i++) step(1'b1, "sel_release");
    end
    checks++;
    assert (out_seq === 4'b1010) else begin
      errors++;
      $error("FAIL selector_seq observed=%b expected=1010", out_seq);
    end
    $display("selector: out1 sequence (msb last) = %b", out_seq);

    // Randomized runs against the model, with occasional async resets.
    npress = 0;
    nrel = 0;
    for (int r = 0; r < 300; r++) begin
      logic b;
      int len;
      b   = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 7));
      for (int i = 0; i < len; i++) begin
        step(b, "random");
        npress += int'(press_pulse);
        nrel   += int'(release_pulse);
        check("random_pulse_excl", press_pulse & release_pulse, 1'b0);
      end
      if ($urandom_range(0, 49) == 0) begin
        async_reset_on("random_reset");
        step(b, "random_reset_hold");
        rst = 1'b0;
      end
    end
    $display("random: presses=%0d releases=%0d", npress, nrel);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
